mac_div_block: RTL

MAC_DIV_BLOCK -- requirements
Module: mac_div_block

---
 rtl/mac_div_block.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mac_div_block.sv
// Lane-configurable radix-2 restoring divider: 1x32, 2x16 or 4x8 lanes.
// Each BUSY step retires one quotient bit per lane; lanes never interact.
module mac_div_block #(
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_CONF_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [MAC_CONF_WIDTH-1:0]   cfg,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [4*MAC_MIN_WIDTH-1:0]  dividend,
  input  logic [4*MAC_MIN_WIDTH-1:0]  divisor,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [4*MAC_MIN_WIDTH-1:0]  quotient,
  output logic [4*MAC_MIN_WIDTH-1:0]  remainder,
  output logic [3:0]                  dz,
  output logic                        cfg_err
);

  localparam int W  = 4 * MAC_MIN_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [MAC_CONF_WIDTH-1:0] C_DUAL = MAC_CONF_WIDTH'(1);
  localparam logic [MAC_CONF_WIDTH-1:0] C_QUAD = MAC_CONF_WIDTH'(2);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } st_t;

  st_t st_q, st_n;

  logic [CW-1:0]             cnt_q;
  logic [W-1:0]              a_q;
  logic [W-1:0]              r_q;
  logic [W-1:0]              b_q;
  logic [MAC_CONF_WIDTH-1:0] cfg_q;
  logic [3:0]                dz_q;
  logic                      err_q;

  logic acc, stp;
  logic m_dual, m_quad, rsv;

  logic [2:0][W-1:0] a_n;
  logic [2:0][W-1:0] r_n;
  logic [2:0][3:0]   dz_m;
  logic [W-1:0]      a_step;
  logic [W-1:0]      r_step;
  logic [CW-1:0]     n_ld;
  logic [3:0]        dz_ld;

  // a_q doubles as dividend shifter and quotient collector
  for (genvar m = 0; m < 3; m++) begin : g_mode
    localparam int LW = W >> m;
    localparam int NL = 1 << m;
    for (genvar i = 0; i < NL; i++) begin : g_lane
      logic [LW:0]   rr;
      logic [LW-1:0] df;
      logic          ge;
      assign rr = {r_q[i*LW +: LW], a_q[i*LW+LW-1]};
      assign ge = rr >= {1'b0, b_q[i*LW +: LW]};
      assign df = rr[LW-1:0] - b_q[i*LW +: LW];
      assign a_n[m][i*LW +: LW] = {a_q[i*LW +: LW-1], ge};
      assign r_n[m][i*LW +: LW] = ge ? df : rr[LW-1:0];
      assign dz_m[m][i] = ~|divisor[i*LW +: LW];
    end
    for (genvar i = NL; i < 4; i++) begin : g_pad
      assign dz_m[m][i] = 1'b0;
    end
  end

  assign m_dual = cfg == C_DUAL;
  assign m_quad = cfg == C_QUAD;
  assign rsv    = cfg > C_QUAD;

  always_comb begin
    n_ld  = CW'(W - 1);
    dz_ld = dz_m[0];
    unique case (1'b1)
      m_dual: begin
        n_ld  = CW'(W / 2 - 1);
        dz_ld = dz_m[1];
      end
      m_quad: begin
        n_ld  = CW'(W / 4 - 1);
        dz_ld = dz_m[2];
      end
      rsv: dz_ld = '0;
      default: ;
    endcase
  end

  always_comb begin
    a_step = a_n[0];
    r_step = r_n[0];
    if (cfg_q == C_DUAL) begin
      a_step = a_n[1];
      r_step = r_n[1];
    end else if (cfg_q == C_QUAD) begin
      a_step = a_n[2];
      r_step = r_n[2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) st_q <= IDLE;
    else      st_q <= st_n;
  end

  always_comb begin
    st_n = st_q;
    unique case (st_q)
      IDLE: if (acc) st_n = rsv ? DONE : BUSY;
      BUSY: if (en && cnt_q == '0) st_n = DONE;
      DONE: if (out_ready) st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst & (st_q == IDLE);
    out_valid = st_q == DONE;
    stp       = en & (st_q == BUSY);
    acc       = in_valid & in_ready & en;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      a_q   <= '0;
      r_q   <= '0;
      b_q   <= '0;
      cfg_q <= '0;
      dz_q  <= '0;
      err_q <= 1'b0;
    end else if (acc) begin
      cnt_q <= n_ld;
      a_q   <= rsv ? '0 : dividend;
      r_q   <= '0;
      b_q   <= divisor;
      cfg_q <= cfg;
      dz_q  <= dz_ld;
      err_q <= rsv;
    end else if (stp) begin
      a_q <= a_step;
      r_q <= r_step;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign quotient  = a_q;
  assign remainder = r_q;
  assign dz        = dz_q;
  assign cfg_err   = err_q;

endmodule
